episode_trace_recorder: RTL and testbench



---
 rtl/grid_pkg.sv | 28 ++
 rtl/episode_trace_recorder_trace_buffer.sv | 30 +++
 rtl/episode_trace_recorder.sv | 152 +++++++++++++++
 tb/tb_episode_trace_recorder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared grid-world definitions: state width, goal default, outcome and FSM
// encodings, and the hole-set lookup reused across the Q-learning datapath.
package grid_pkg;

  localparam int STATE_W        = 6;
  localparam int GOAL_STATE_DEF = 25;

  typedef enum logic [1:0] {
    OUT_GOAL    = 2'b00,
    OUT_HOLE    = 2'b01,
    OUT_TIMEOUT = 2'b10,
    OUT_ABORT   = 2'b11
  } outcome_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECORD,
    ST_DRAIN
  } fsm_t;

  function automatic logic is_hole(input logic [STATE_W-1:0] s);
    case (s)
      6'd5, 6'd7, 6'd8, 6'd14, 6'd17, 6'd19, 6'd20, 6'd22: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/episode_trace_recorder_trace_buffer.sv
// Trajectory register file: one synchronous write port, one asynchronous read
// port. Writes and reads never overlap, so no bypass path exists.
module trace_buffer
  import grid_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [STATE_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [STATE_W-1:0] rd_data
);

  logic [STATE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/episode_trace_recorder.sv
// Records the per-step state trajectory of each episode, classifies the outcome
// and drains it over a valid/ready stream. Define TRACE_BEST_EN for best-goal tracking.
module episode_trace_recorder
  import grid_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int MAX_STEPS  = 15,
  parameter int GOAL_STATE = GOAL_STATE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ep_start,
  input  logic               step_valid,
  input  logic [STATE_W-1:0] step_state,
  input  logic [9:0]         episode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               out_last,
  output logic               sum_valid,
  output logic [9:0]         sum_episode,
  output logic [4:0]         sum_steps,
  output logic [1:0]         sum_outcome,
  output logic [7:0]         missed_cnt
`ifdef TRACE_BEST_EN
  ,
  output logic [4:0]         best_steps,
  output logic [9:0]         best_episode
`endif
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fsm_t               state_q;
  logic [PW-1:0]      wr_ptr, rd_ptr, steps_q, wr_ptr_nxt, end_steps;
  logic               wr_en, end_now, missed_inc, beat_fire;
  outcome_t           end_oc;
  logic [STATE_W-1:0] rd_data;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign wr_ptr_nxt = PW'(wr_ptr + 1'b1);
  assign wr_en      = (state_q == ST_RECORD) && step_valid && !ep_start;
  assign beat_fire  = out_valid && out_ready;
  assign missed_inc = ep_start && ((state_q == ST_DRAIN) ||
                                   ((state_q == ST_RECORD) && (wr_ptr != '0)));

  // Episode termination: a terminal state outranks the step limit
  always_comb begin
    end_now   = 1'b0;
    end_oc    = OUT_GOAL;
    end_steps = wr_ptr_nxt;
    if (state_q == ST_RECORD) begin
      if (ep_start) begin
        if (wr_ptr != '0) begin
          end_now   = 1'b1;
          end_oc    = OUT_ABORT;
          end_steps = wr_ptr;
        end
      end else if (step_valid) begin
        if (step_state == STATE_W'(GOAL_STATE)) begin
          end_now = 1'b1;
          end_oc  = OUT_GOAL;
        end else if (is_hole(step_state)) begin
          end_now = 1'b1;
          end_oc  = OUT_HOLE;
        end else if (wr_ptr_nxt == PW'(MAX_STEPS)) begin
          end_now = 1'b1;
          end_oc  = OUT_TIMEOUT;
        end
      end
    end
  end

  trace_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (step_state),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      steps_q      <= '0;
      out_valid    <= 1'b0;
      sum_valid    <= 1'b0;
      sum_episode  <= '0;
      sum_outcome  <= '0;
      missed_cnt   <= '0;
`ifdef TRACE_BEST_EN
      best_steps   <= 5'h1F;
      best_episode <= '0;
`endif
    end else begin
      if (missed_inc) missed_cnt <= sat_inc8(missed_cnt);
      case (state_q)
        ST_IDLE: begin
          if (ep_start) begin
            state_q     <= ST_RECORD;
            sum_episode <= episode;
            wr_ptr      <= '0;
          end
        end
        ST_RECORD: begin
          if (wr_en) wr_ptr <= wr_ptr_nxt;
          if (ep_start && (wr_ptr == '0)) sum_episode <= episode;
          if (end_now) begin
            state_q     <= ST_DRAIN;
            steps_q     <= end_steps;
            sum_outcome <= end_oc;
            rd_ptr      <= '0;
            out_valid   <= 1'b1;
            sum_valid   <= 1'b1;
`ifdef TRACE_BEST_EN
            // Strict less-than keeps the earlier episode on a tie
            if ((end_oc == OUT_GOAL) && (5'(end_steps) < best_steps)) begin
              best_steps   <= 5'(end_steps);
              best_episode <= sum_episode;
            end
`endif
          end
        end
        ST_DRAIN: begin
          if (beat_fire) begin
            if (out_last) begin
              state_q   <= ST_IDLE;
              out_valid <= 1'b0;
              sum_valid <= 1'b0;
            end else begin
              rd_ptr <= PW'(rd_ptr + 1'b1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_data  = out_valid ? rd_data : '0;
  assign out_last  = out_valid && (PW'(rd_ptr + 1'b1) == steps_q);
  assign sum_steps = 5'(steps_q);

endmodule

// File: tb/tb_episode_trace_recorder.sv
// Directed bench for episode_trace_recorder; best-goal checks run when
// TRACE_BEST_EN is defined.
module tb_episode_trace_recorder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ep_start = 1'b0;
  logic       step_valid = 1'b0;
  logic [5:0] step_state = '0;
  logic [9:0] episode = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out_data;
  logic       out_last;
  logic       sum_valid;
  logic [9:0] sum_episode;
  logic [4:0] sum_steps;
  logic [1:0] sum_outcome;
  logic [7:0] missed_cnt;
`ifdef TRACE_BEST_EN
  logic [4:0] best_steps;
  logic [9:0] best_episode;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [5:0] beats[$];

  episode_trace_recorder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ep_start    (ep_start),
    .step_valid  (step_valid),
    .step_state  (step_state),
    .episode     (episode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .sum_valid   (sum_valid),
    .sum_episode (sum_episode),
    .sum_steps   (sum_steps),
    .sum_outcome (sum_outcome),
    .missed_cnt  (missed_cnt)
`ifdef TRACE_BEST_EN
    ,
    .best_steps  (best_steps),
    .best_episode(best_episode)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start an episode and present every state queued in beats, one per cycle
  task automatic record(input logic [9:0] ep);
    ep_start = 1'b1;
    episode  = ep;
    tick();
    ep_start = 1'b0;
    foreach (beats[i]) begin
      step_valid = 1'b1;
      step_state = beats[i];
      tick();
    end
    step_valid = 1'b0;
  endtask

  task automatic drain_all(input string tag, input logic [1:0] oc, input logic [9:0] ep);
    chk({tag, "_sum_valid"}, sum_valid, 1);
    chk({tag, "_sum_steps"}, sum_steps, beats.size());
    chk({tag, "_sum_outcome"}, sum_outcome, oc);
    chk({tag, "_sum_episode"}, sum_episode, ep);
    out_ready = 1'b1;
    foreach (beats[i]) begin
      chk($sformatf("%s_valid%0d", tag, i), out_valid, 1);
      chk($sformatf("%s_data%0d", tag, i), out_data, beats[i]);
      chk($sformatf("%s_last%0d", tag, i), out_last, (i == beats.size() - 1));
      tick();
    end
    chk({tag, "_done_valid"}, out_valid, 0);
    chk({tag, "_done_sum_valid"}, sum_valid, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sum_valid", sum_valid, 0);
    chk("rst_sum_steps", sum_steps, 0);
    chk("rst_sum_outcome", sum_outcome, 0);
    chk("rst_sum_episode", sum_episode, 0);
    chk("rst_missed", missed_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Goal path
    beats = '{6'd2, 6'd3, 6'd4, 6'd9, 6'd10, 6'd15, 6'd25};
    record(10'd3);
    drain_all("goal", 2'b00, 10'd3);

    // Hole
    beats = '{6'd6, 6'd7};
    record(10'd4);
    drain_all("hole", 2'b01, 10'd4);

    // Timeout after 15 non-terminal steps
    beats.delete();
    for (int i = 0; i < 15; i++) beats.push_back((i % 2 == 0) ? 6'd1 : 6'd2);
    record(10'd5);
    drain_all("timeout", 2'b10, 10'd5);

    // Goal on the 15th step beats timeout
    beats[14] = 6'd25;
    record(10'd6);
    drain_all("goal15", 2'b00, 10'd6);

    // Abort, then a missed episode while the stream stalls
    beats = '{6'd2, 6'd3};
    record(10'd7);
    ep_start = 1'b1;
    episode  = 10'd8;
    tick();
    chk("abort_missed", missed_cnt, 1);
    chk("abort_valid", out_valid, 1);
    ep_start = 1'b1;
    episode  = 10'd9;
    tick();
    ep_start = 1'b0;
    chk("drain_missed", missed_cnt, 2);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_valid%0d", i), out_valid, 1);
      chk($sformatf("stall_data%0d", i), out_data, 6'd2);
      chk($sformatf("stall_last%0d", i), out_last, 0);
      chk($sformatf("stall_outcome%0d", i), sum_outcome, 2'b11);
      chk($sformatf("stall_steps%0d", i), sum_steps, 5'd2);
      tick();
    end
    drain_all("abort", 2'b11, 10'd7);
    chk("abort_after_missed", missed_cnt, 2);

    // Asynchronous reset in the middle of a drain
    beats = '{6'd2, 6'd7};
    record(10'd20);
    chk("mid_valid", out_valid, 1);
    chk("mid_outcome", sum_outcome, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_sum_valid", sum_valid, 0);
    chk("arst_sum_outcome", sum_outcome, 0);
    chk("arst_sum_episode", sum_episode, 0);
    chk("arst_sum_steps", sum_steps, 0);
    chk("arst_missed", missed_cnt, 0);
    tick();
    rst_n = 1'b1;
    step_valid = 1'b1;
    step_state = 6'd25;
    tick();
    tick();
    step_valid = 1'b0;
    chk("idle_ignores_step", out_valid, 0);

`ifdef TRACE_BEST_EN
    chk("best_rst_steps", best_steps, 5'h1F);
    chk("best_rst_episode", best_episode, 0);
    beats = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd9, 6'd10, 6'd15, 6'd24, 6'd25};
    record(10'd10);
    chk("best9_steps", best_steps, 5'd9);
    chk("best9_episode", best_episode, 10'd10);
    drain_all("best9", 2'b00, 10'd10);
    beats = '{6'd2, 6'd3, 6'd4, 6'd9, 6'd10, 6'd15, 6'd25};
    record(10'd11);
    drain_all("best7a", 2'b00, 10'd11);
    record(10'd12);
    drain_all("best7b", 2'b00, 10'd12);
    chk("best_steps", best_steps, 5'd7);
    chk("best_episode", best_episode, 10'd11);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
